// File: rtl/reorder_fifo_if.sv
// Handshake bundle for reorder_fifo: allocation, out-of-order write-back and in-order retire.
// The master side is the producer/consumer and the slave side is the buffer.
interface reorder_fifo_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned ID_W = $clog2(DEPTH);

    logic              alloc_i;
    logic [ID_W-1:0]   alloc_id_o;
    logic              full_o;
    logic              wb_i;
    logic [ID_W-1:0]   wb_id_i;
    logic [DATA_W-1:0] wb_data_i;
    logic              pop_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              empty_o;
    logic [ID_W:0]     count_o;

    modport master (
        output alloc_i, wb_i, wb_id_i, wb_data_i, pop_i,
        input  alloc_id_o, full_o, data_o, valid_o, empty_o, count_o
    );

    modport slave (
        input  alloc_i, wb_i, wb_id_i, wb_data_i, pop_i,
        output alloc_id_o, full_o, data_o, valid_o, empty_o, count_o
    );
endinterface

// File: rtl/reorder_fifo.sv
// Reorder buffer: entries are allocated in program order, completed out of order by ID,
// and retired from the head only once completed.
module reorder_fifo #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input logic           clk_i,
    input logic           reset_i,
    reorder_fifo_if.slave bus
);
    localparam int unsigned ID_W = $clog2(DEPTH);
    localparam logic [ID_W:0] PTR_ONE = {{ID_W{1'b0}}, 1'b1};

    logic [ID_W:0]     head, head_next;
    logic [ID_W:0]     tail, tail_next;
    logic [ID_W:0]     count, count_next;
    logic [DEPTH-1:0]  done, done_next;
    logic [DATA_W-1:0] payload [DEPTH];

    logic [ID_W-1:0] head_idx;
    logic [ID_W-1:0] tail_idx;
    logic [ID_W-1:0] wb_offset;
    logic            empty;
    logic            full;
    logic            valid;
    logic            alloc_ok;
    logic            pop_ok;
    logic            wb_allocated;
    logic            wb_ok;

    assign head_idx = head[ID_W-1:0];
    assign tail_idx = tail[ID_W-1:0];

    assign empty = (head == tail);
    assign full  = (head_idx == tail_idx) && (head[ID_W] != tail[ID_W]);
    assign valid = !empty && done[head_idx];

    assign alloc_ok = bus.alloc_i && !full;
    assign pop_ok   = bus.pop_i && valid;

    // An ID is live when its distance from the head is below the occupancy.
    assign wb_offset    = bus.wb_id_i - head_idx;
    assign wb_allocated = ({1'b0, wb_offset} < count);
    assign wb_ok        = bus.wb_i && wb_allocated && !done[bus.wb_id_i];

    // The three done-bit updates never collide: alloc targets a free slot, a popped head
    // is already done so write-back cannot target it.
    always_comb begin
        head_next  = head;
        tail_next  = tail;
        count_next = count;
        done_next  = done;
        if (alloc_ok) begin
            done_next[tail_idx] = 1'b0;
            tail_next           = tail + PTR_ONE;
        end
        if (wb_ok) begin
            done_next[bus.wb_id_i] = 1'b1;
        end
        if (pop_ok) begin
            done_next[head_idx] = 1'b0;
            head_next           = head + PTR_ONE;
        end
        unique case ({alloc_ok, pop_ok})
            2'b10:   count_next = count + PTR_ONE;
            2'b01:   count_next = count - PTR_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            done  <= done_next;
        end
    end

    // Payload storage carries no reset; the done bits alone qualify it.
    always_ff @(posedge clk_i) begin
        if (!reset_i && wb_ok) begin
            payload[bus.wb_id_i] <= bus.wb_data_i;
        end
    end

    assign bus.alloc_id_o = tail_idx;
    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.valid_o    = valid;
    assign bus.data_o     = payload[head_idx];
    assign bus.count_o    = count;
endmodule

// File: doc/reorder_fifo.md
REORDER_FIFO -- requirements
Module: reorder_fifo

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count (power of two, >=2).
REQ-003 Derived ID_W SHALL be $clog2(DEPTH) and SHALL NOT be overridable.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  sole clock, all state updates on rising edge.
REQ-006 reset_i  in  1  synchronous active-high reset.
REQ-007 alloc_i  in  1  request to allocate the next entry in program order.
REQ-008 alloc_id_o  out  ID_W  ID granted to an alloc accepted this cycle (tail index).
REQ-009 full_o  out  1  all DEPTH entries allocated.
REQ-010 wb_i  in  1  out-of-order completion strobe.
REQ-011 wb_id_i  in  ID_W  entry being completed.
REQ-012 wb_data_i  in  DATA_W  result for that entry.
REQ-013 pop_i  in  1  consumer takes the head entry.
REQ-014 data_o  out  DATA_W  head entry payload.
REQ-015 valid_o  out  1  head entry allocated and completed.
REQ-016 empty_o  out  1  no entries allocated.
REQ-017 count_o  out  ID_W+1  number of allocated entries, 0..DEPTH.

Function
REQ-018 Head and tail pointers SHALL be ID_W+1 bits; low ID_W bits index storage, MSB is the wrap bit.
REQ-019 empty_o SHALL be 1 iff head==tail; full_o SHALL be 1 iff low bits are equal and MSBs differ.
REQ-020 Each entry SHALL hold a done bit plus DATA_W payload.
REQ-021 Alloc accepted iff alloc_i && !full_o (current-cycle state); on acceptance, done[tail] clears and tail increments at the clock edge.
REQ-022 alloc_id_o SHALL equal tail[ID_W-1:0] combinationally, regardless of alloc_i.
REQ-023 Write-back accepted iff wb_i and wb_id_i is allocated and its done bit is 0; payload stored, done set at the edge.
REQ-024 Write-back to an unallocated or already-done ID SHALL be ignored with no state change.
REQ-025 valid_o SHALL be !empty_o && done[head], combinational from registered state; data_o = payload[head].
REQ-026 Pop accepted iff pop_i && valid_o; head increments, done[head] clears; pop with valid_o=0 SHALL be ignored.
REQ-027 data_o is don't-care while valid_o=0.
REQ-028 Write-back to the head is visible on valid_o/data_o the cycle after acceptance (one-cycle latency, no bypass).
REQ-029 Same-cycle alloc and pop: both evaluated on pre-edge state; count_o unchanged if both accepted.
REQ-030 Alloc when full is refused even with a concurrent accepted pop; pop when empty is refused even with a concurrent alloc.
REQ-031 Write-back in the same cycle as allocation of that ID SHALL be ignored (ID not yet allocated).
REQ-032 Write-back to a non-head entry concurrent with a pop SHALL both take effect.
REQ-033 count_o SHALL equal tail-head (mod 2^(ID_W+1)), registered, +1 / -1 / 0 per accepted alloc/pop.
REQ-034 Pointers SHALL wrap modulo 2*DEPTH with no lost or duplicated entries.

Reset
REQ-035 When reset_i=1 at a clock edge: head=tail=0, all done bits=0, count_o=0; reset overrides all same-cycle alloc/wb/pop.
REQ-036 After reset: empty_o=1, full_o=0, valid_o=0, alloc_id_o=0; payload storage is not reset.
REQ-037 Reset mid-operation SHALL discard all outstanding entries; later write-backs to old IDs are ignored until re-allocated.

Verification (DATA_W=4, DEPTH=16)
REQ-038 Reset, alloc 3 -> IDs 0,1,2 granted, count_o=3; wb id2=0xC, id0=0xA, id1=0xB -> valid_o rises only after id0 wb; pops return 0xA,0xB,0xC in order.
REQ-039 Alloc 16 -> full_o=1, count_o=16; 17th alloc ignored; alloc+pop same cycle while full (head done) -> pop accepted, alloc refused, count_o=15.
REQ-040 Run 40 alloc/wb/pop rounds -> pointers wrap twice, IDs repeat 0..15, all data in order, empty_o=1 at end.
REQ-041 wb to unallocated id5 on empty buffer, then duplicate wb to completed id0 with 0xF -> no state change; id0 still pops original 0x3.
REQ-042 Alloc 4, wb ids 0-3, assert reset_i with pop_i=1 -> next cycle empty_o=1, count_o=0, valid_o=0; wb id1 afterwards ignored.
REQ-043 Empty buffer, alloc_i=1 and wb_i=1 id0 same cycle -> wb ignored, valid_o stays 0 until later wb id0.
